// File: rtl/bilinear_pixel_fetch.sv
// 2x2 bilinear neighbourhood fetcher over a single-port byte SRAM, with an idle-time image load port.
// Optional macro FETCH_STATS_EN adds a saturating 16-bit fetch_count of retired neighbourhoods.
module bilinear_pixel_fetch #(
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned IMG_W      = 16,
    parameter int unsigned IMG_H      = 16,
    parameter int unsigned COORD_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef FETCH_STATS_EN
    output logic [15:0]           fetch_count,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COORD_BITS-1:0] req_x,
    input  logic [COORD_BITS-1:0] req_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  p00,
    output logic [DATA_BITS-1:0]  p01,
    output logic [DATA_BITS-1:0]  p10,
    output logic [DATA_BITS-1:0]  p11,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_BITS-1:0]  ld_addr,
    input  logic [DATA_BITS-1:0]  ld_data,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_BITS-1:0]  mem_wdata,
    input  logic [DATA_BITS-1:0]  mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t                state, state_n;
    logic [1:0]            idx, idx_n;
    logic [COORD_BITS-1:0] xc, yc, x1, y1;
    logic [COORD_BITS-1:0] req_xc, req_yc, req_x1, req_y1;
    logic [COORD_BITS-1:0] row, col;
    logic [31:0]           lin_addr;
    logic                  req_fire;

    assign req_fire = (state == S_IDLE) && req_valid && !ld_valid;

    // Edge clamp of the incoming coordinate and its right/lower neighbour.
    always_comb begin
        req_xc = (32'(req_x) > IMG_W - 1) ? COORD_BITS'(IMG_W - 1) : req_x;
        req_yc = (32'(req_y) > IMG_H - 1) ? COORD_BITS'(IMG_H - 1) : req_y;
        req_x1 = (32'(req_xc) == IMG_W - 1) ? req_xc : req_xc + COORD_BITS'(1);
        req_y1 = (32'(req_yc) == IMG_H - 1) ? req_yc : req_yc + COORD_BITS'(1);
    end

    // Neighbour selection in raster order, linear address at full width.
    always_comb begin
        row = yc;
        col = xc;
        unique case (idx)
            2'd0: begin row = yc; col = xc; end
            2'd1: begin row = yc; col = x1; end
            2'd2: begin row = y1; col = xc; end
            default: begin row = y1; col = x1; end
        endcase
        lin_addr = 32'(row) * IMG_W + 32'(col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next state and SRAM/handshake drive; load wins over fetch in IDLE.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        req_ready = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_IDLE: begin
                ld_ready  = 1'b1;
                req_ready = !ld_valid;
                if (ld_valid) begin
                    mem_we    = rst_n;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                end else if (req_valid) begin
                    state_n = S_ISSUE;
                    idx_n   = 2'd0;
                end
            end
            S_ISSUE: begin
                mem_addr = ADDR_BITS'(lin_addr);
                idx_n    = idx + 2'd1;
                if (idx == 2'd3) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: state_n = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Coordinate latch, pixel capture one cycle behind the issued address, output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xc        <= '0;
            yc        <= '0;
            x1        <= '0;
            y1        <= '0;
            p00       <= '0;
            p01       <= '0;
            p10       <= '0;
            p11       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (req_fire) begin
                xc <= req_xc;
                yc <= req_yc;
                x1 <= req_x1;
                y1 <= req_y1;
            end
            if (state == S_ISSUE) begin
                case (idx)
                    2'd1:    p00 <= mem_rdata;
                    2'd2:    p01 <= mem_rdata;
                    2'd3:    p10 <= mem_rdata;
                    default: ;
                endcase
            end
            if (state == S_DRAIN) begin
                p11 <= mem_rdata;
            end
            out_valid <= (state == S_DRAIN) || (out_valid && !out_ready);
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'd0;
        end else if (out_valid && out_ready && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bilinear_pixel_fetch.sv
// Randomized bench for bilinear_pixel_fetch: behavioural neighbourhood model, SRAM model and per-cycle compare.
`timescale 1ns/1ps
module tb_bilinear_pixel_fetch;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int IW = 16;
    localparam int IH = 16;
    localparam int CB = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, out_valid, out_ready;
    logic [CB-1:0] req_x, req_y;
    logic [DB-1:0] p00, p01, p10, p11;
    logic          ld_valid, ld_ready, mem_we;
    logic [AB-1:0] ld_addr, mem_addr;
    logic [DB-1:0] ld_data, mem_wdata, mem_rdata;
`ifdef FETCH_STATS_EN
    logic [15:0]   fetch_count;
`endif

    bilinear_pixel_fetch #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .IMG_W(IW), .IMG_H(IH), .COORD_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FETCH_STATS_EN
        .fetch_count(fetch_count),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with registered read data.
    logic [DB-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int misc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Model: image contents as written through the load port; expected fetch per accepted request.
    typedef struct {
        logic [3:0][7:0] p;
        logic [3:0][7:0] a;
        int              acc;
    } exp_t;

    logic [7:0] img [256];
    exp_t       exp_q [$];
    int         retires = 0;
    logic [31:0] last_p = 32'd0;

    function automatic exp_t model(input int x, input int y, input int acc);
        exp_t e;
        int xc, yc, xn, yn;
        int r [4];
        int c [4];
        xc = (x > IW - 1) ? IW - 1 : x;
        yc = (y > IH - 1) ? IH - 1 : y;
        xn = (xc == IW - 1) ? xc : xc + 1;
        yn = (yc == IH - 1) ? yc : yc + 1;
        r = '{yc, yc, yn, yn};
        c = '{xc, xn, xc, xn};
        for (int k = 0; k < 4; k++) begin
            e.a[k] = 8'(r[k] * IW + c[k]);
            e.p[k] = img[e.a[k]];
        end
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        int   ph;
        logic busy;
        if (!rst_n) begin
            exp_q.delete();
            retires = 0;
        end else begin
`ifdef FETCH_STATS_EN
            chk("fetch_count", 32'(fetch_count), 32'((retires > 65535) ? 65535 : retires));
`endif
            busy = (exp_q.size() != 0);
            chk("ld_ready", 32'(ld_ready), 32'(!busy));
            chk("req_ready", 32'(req_ready), 32'(!busy && !ld_valid));
            if (!busy) begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                if (ld_valid) begin
                    chk("ld_we", 32'(mem_we), 32'd1);
                    chk("ld_addr", 32'(mem_addr), 32'(ld_addr));
                    chk("ld_wdata", 32'(mem_wdata), 32'(ld_data));
                    img[ld_addr] = ld_data;
                end else begin
                    chk("idle_we", 32'(mem_we), 32'd0);
                    chk("idle_addr", 32'(mem_addr), 32'd0);
                    chk("idle_wdata", 32'(mem_wdata), 32'd0);
                    if (req_valid) exp_q.push_back(model(int'(req_x), int'(req_y), cyc + 1));
                end
            end else begin
                e  = exp_q[0];
                ph = cyc - e.acc;
                chk("busy_we", 32'(mem_we), 32'd0);
                chk("busy_wdata", 32'(mem_wdata), 32'd0);
                if (ph <= 3) chk("issue_addr", 32'(mem_addr), 32'(e.a[ph]));
                if (ph == 4) chk("drain_addr", 32'(mem_addr), 32'd0);
                chk("out_valid_timing", 32'(out_valid), 32'(ph >= 5));
                if (out_valid) begin
                    chk("pixels", {p11, p10, p01, p00}, 32'(e.p));
                    if (out_ready) begin
                        last_p = {p11, p10, p01, p00};
                        retires++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Consumer ready: 0 = always ready, 1 = stalled, 2 = random.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        logic hs;
        int   n;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        n = 0;
        do begin
            hs = ld_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) chk("load_timeout", 32'd0, 32'd1);
        ld_valid = 1'b0;
    endtask

    task automatic request(input int x, input int y);
        logic hs;
        int   n;
        req_valid = 1'b1;
        req_x     = CB'(x);
        req_y     = CB'(y);
        n = 0;
        do begin
            hs = req_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) chk("req_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lit [4];
        int r0;
        int n;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        out_ready = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = 8'd7;
        ld_data   = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pixels", {p11, p10, p01, p00}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        for (int a = 0; a < 256; a++) load(8'(a), 8'(a));

        // Interior fetch with address sequence pinned.
        lit = '{35, 36, 51, 52};
        request(3, 2);
        for (int k = 0; k < 4; k++) begin
            chk("addr_3_2", 32'(mem_addr), 32'(lit[k]));
            tick();
        end
        wait_idle();
        chk("pix_3_2", last_p, pk(35, 36, 51, 52));

        request(15, 4);
        wait_idle();
        chk("pix_15_4", last_p, pk(79, 79, 95, 95));
        request(15, 15);
        wait_idle();
        chk("pix_15_15", last_p, pk(255, 255, 255, 255));
        request(9, 20);
        wait_idle();
        chk("pix_9_20", last_p, pk(249, 250, 249, 250));

        // Backpressure in OUT, with a load pending that must not be taken.
        rdy_mode = 1;
        request(6, 7);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_reach_out", 32'(out_valid), 32'd1);
        ld_valid = 1'b1;
        ld_addr  = 8'd3;
        ld_data  = 8'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_ld_ready", 32'(ld_ready), 32'd0);
        end
        ld_valid = 1'b0;
        r0 = retires;
        rdy_mode = 0;
        wait_idle();
        chk("bp_one_handshake", 32'(retires - r0), 32'd1);
        chk("pix_6_7", last_p, pk(118, 119, 134, 135));

        // Load and request together: load first, request next cycle.
        ld_valid  = 1'b1;
        ld_addr   = 8'd200;
        ld_data   = 8'd200;
        req_valid = 1'b1;
        req_x     = CB'(5);
        req_y     = CB'(5);
        #1;
        chk("both_req_ready", 32'(req_ready), 32'd0);
        chk("both_mem_we", 32'(mem_we), 32'd1);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("both_req_next", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("both_accepted", 32'(exp_q.size()), 32'd1);
        wait_idle();
        chk("pix_5_5", last_p, pk(85, 86, 101, 102));

        // Reset while issuing idx2; the fetch must vanish.
        request(4, 4);
        tick();
        tick();
        rst_n    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 8'd9;
        ld_data  = 8'd99;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_pixels", {p11, p10, p01, p00}, 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_idle", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (10) tick();
        request(0, 0);
        wait_idle();
        chk("pix_0_0", last_p, pk(0, 1, 16, 17));
`ifdef FETCH_STATS_EN
        chk("fetch_count_after_rst", 32'(fetch_count), 32'd1);
`endif

        // Randomized traffic: loads, clamped and in-range requests, random consumer stalls.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) load(8'($urandom), 8'($urandom));
            end
            request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
        wait_idle();
        rdy_mode = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
